// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, shift right, shift left or parallel load,
// with an optional rotate mode, a registered shifted-out bit and a saturating shift counter.
`timescale 1ns/1ps

module univ_shift_reg #(
  parameter int WIDTH  = 4,
  parameter int ROTATE = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [1:0]                 mode,
  input  logic [WIDTH-1:0]           data_in,
  input  logic                       sin_r,
  input  logic                       sin_l,
  output logic [WIDTH-1:0]           q,
  output logic                       sout,
  output logic [$clog2(WIDTH+1)-1:0] cnt,
  output logic                       drained
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("univ_shift_reg: WIDTH must be in 2..32");
  end

  logic [WIDTH-1:0] q_q, q_d;
  logic             sout_q, sout_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  mode_e mode_sel;
  logic  fill_r;
  logic  fill_l;
  logic  cnt_inc;

  assign mode_sel = mode_e'(mode);

  // In rotate mode the outgoing bit re-enters at the opposite end.
  assign fill_r = (ROTATE != 0) ? q_q[0]       : sin_r;
  assign fill_l = (ROTATE != 0) ? q_q[WIDTH-1] : sin_l;

  assign cnt_inc = (cnt_q < CNT_FULL);

  // NOTE: every signal written here gets a default first, so no path through
  // the case can leave a value unassigned and infer a latch.
  always_comb begin
    q_d    = q_q;
    sout_d = sout_q;
    cnt_d  = cnt_q;
    if (en) begin
      case (mode_sel)
        MODE_SHR: begin
          q_d    = {fill_r, q_q[WIDTH-1:1]};
          sout_d = q_q[0];
          cnt_d  = cnt_inc ? cnt_q + CW'(1) : cnt_q;
        end
        MODE_SHL: begin
          q_d    = {q_q[WIDTH-2:0], fill_l};
          sout_d = q_q[WIDTH-1];
          cnt_d  = cnt_inc ? cnt_q + CW'(1) : cnt_q;
        end
        MODE_LOAD: begin
          q_d   = data_in;
          cnt_d = '0;
        end
        default: ;
      endcase
    end
  end

  // NOTE: state uses non-blocking assignments so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q    <= '0;
      sout_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      q_q    <= q_d;
      sout_q <= sout_d;
      cnt_q  <= cnt_d;
    end
  end

  assign q       = q_q;
  assign sout    = sout_q;
  assign cnt     = cnt_q;
  assign drained = (cnt_q == CNT_FULL);

endmodule

// File: tb/tb_univ_shift_reg.sv
// Scoreboard bench for univ_shift_reg: a shifting instance and a rotating instance
// share stimulus; an arithmetic reference model predicts both, a monitor compares.
`timescale 1ns/1ps

module tb_univ_shift_reg;

  localparam int W   = 4;
  localparam int TOP = 1 << (W - 1);
  localparam int MOD = 1 << W;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic [1:0]   mode = 2'b00;
  logic [W-1:0] data_in = '0;
  logic         sin_r = 1'b0;
  logic         sin_l = 1'b0;

  logic [W-1:0] q0, q1;
  logic         sout0, sout1;
  logic [2:0]   cnt0, cnt1;
  logic         drained0, drained1;

  univ_shift_reg #(.WIDTH(W), .ROTATE(0)) u_dut_shift (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .data_in(data_in),
    .sin_r(sin_r), .sin_l(sin_l), .q(q0), .sout(sout0), .cnt(cnt0), .drained(drained0)
  );

  univ_shift_reg #(.WIDTH(W), .ROTATE(1)) u_dut_rot (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .data_in(data_in),
    .sin_r(sin_r), .sin_l(sin_l), .q(q1), .sout(sout1), .cnt(cnt1), .drained(drained1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: index 0 takes serial inputs, index 1 rotates.
  int mq[2], ms[2], mc[2];

  typedef struct {
    int due;
    int q[2];
    int s[2];
    int c[2];
  } exp_t;

  exp_t sb[$];

  task automatic model_reset();
    for (int r = 0; r < 2; r++) begin
      mq[r] = 0; ms[r] = 0; mc[r] = 0;
    end
  endtask

  task automatic model_apply(input bit e, input int m, input int d, input int sr, input int sl);
    int out_bit;
    for (int r = 0; r < 2; r++) begin
      if (e) begin
        if (m == 1) begin
          out_bit = mq[r] % 2;
          mq[r]   = mq[r] / 2 + ((r == 1) ? out_bit : sr) * TOP;
          ms[r]   = out_bit;
          if (mc[r] < W) mc[r]++;
        end else if (m == 2) begin
          out_bit = mq[r] / TOP;
          mq[r]   = (mq[r] * 2) % MOD + ((r == 1) ? out_bit : sl);
          ms[r]   = out_bit;
          if (mc[r] < W) mc[r]++;
        end else if (m == 3) begin
          mq[r] = d;
          mc[r] = 0;
        end
      end
    end
  endtask

  // One operation per cycle: drive after the edge, predict, queue the expectation.
  task automatic do_op(input bit e, input int m, input int d, input int sr, input int sl);
    exp_t x;
    @(posedge clk);
    #1;
    en = e; mode = m[1:0]; data_in = d[W-1:0]; sin_r = sr[0]; sin_l = sl[0];
    model_apply(e, m, d, sr, sl);
    x.due = cyc + 1;
    for (int r = 0; r < 2; r++) begin
      x.q[r] = mq[r]; x.s[r] = ms[r]; x.c[r] = mc[r];
    end
    sb.push_back(x);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_q_shift"},    32'(q0), 0);
    check({tag, "_q_rot"},      32'(q1), 0);
    check({tag, "_sout_shift"}, 32'(sout0), 0);
    check({tag, "_sout_rot"},   32'(sout1), 0);
    check({tag, "_cnt_shift"},  32'(cnt0), 0);
    check({tag, "_cnt_rot"},    32'(cnt1), 0);
    check({tag, "_drained"},    32'({drained1, drained0}), 0);
  endtask

  // Let the last queued op land, then pull reset between clock edges.
  task automatic do_reset(input string tag);
    @(posedge clk);
    #1;
    en = 1'b0;
    @(negedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    model_reset();
    #1;
    check_zero(tag);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    rst = 1'b1;
  endtask

  // Monitor: outputs are presented every cycle; compare whatever is due.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        x = sb.pop_front();
        check("due_cycle", 32'(x.due), 32'(cyc));
        check("q_shift",       32'(q0),       32'(x.q[0]));
        check("sout_shift",    32'(sout0),    32'(x.s[0]));
        check("cnt_shift",     32'(cnt0),     32'(x.c[0]));
        check("drained_shift", 32'(drained0), 32'(x.c[0] == W));
        check("q_rot",         32'(q1),       32'(x.q[1]));
        check("sout_rot",      32'(sout1),    32'(x.s[1]));
        check("cnt_rot",       32'(cnt1),     32'(x.c[1]));
        check("drained_rot",   32'(drained1), 32'(x.c[1] == W));
      end
    end
  end

  initial begin
    int budget;
    #1 rst = 1'b0;
    model_reset();
    #1 check_zero("por");
    @(negedge clk);
    #1 rst = 1'b1;

    // Load 1011, four right shifts with zero fill.
    do_op(1, 3, 4'b1011, 0, 0);
    repeat (4) do_op(1, 1, 0, 0, 0);
    // Load 0001, three left shifts with one fill.
    do_op(1, 3, 4'b0001, 0, 0);
    repeat (3) do_op(1, 2, 0, 0, 1);
    // Rotate-focused: load 1000, four right shifts with sin_r=1.
    do_op(1, 3, 4'b1000, 0, 0);
    repeat (4) do_op(1, 1, 0, 1, 0);
    // Drained, then two more shifts saturate, then a load clears the count.
    repeat (2) do_op(1, 2, 0, 0, 1);
    do_op(1, 3, 4'h6, 0, 0);
    // Enable low blocks a load for three cycles, then it goes through.
    repeat (3) do_op(0, 3, 4'hF, 1, 1);
    do_op(1, 3, 4'hF, 0, 0);
    // Hold mode and back-to-back direction changes.
    do_op(1, 0, 4'h3, 1, 1);
    do_op(1, 1, 0, 1, 0);
    do_op(1, 2, 0, 0, 0);
    do_op(1, 1, 0, 0, 1);
    do_op(1, 2, 0, 1, 1);
    do_op(1, 2, 0, 1, 0);
    // Reset between edges after two shifts, then load A on release.
    do_op(1, 3, 4'b1011, 0, 0);
    repeat (2) do_op(1, 1, 0, 0, 0);
    do_reset("rst_mid");
    do_op(1, 3, 4'hA, 0, 0);
    do_op(1, 0, 0, 0, 0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 60) == 0) do_reset("rst_rand");
      else do_op(($urandom_range(0, 9) != 0), $urandom_range(0, 3), $urandom_range(0, MOD - 1),
                 $urandom_range(0, 1), $urandom_range(0, 1));
    end

    do_op(0, 0, 0, 0, 0);
    budget = 20;
    while (sb.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    check("scoreboard_drain", 32'(sb.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/univ_shift_reg.md
UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 Parameter WIDTH, default 4: register width in bits; legal range 2..32.
REQ-002 Parameter ROTATE, default 0: 1 = shifts recirculate the outgoing bit and ignore the serial inputs; 0 = shifts take a serial input.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-005 Port en, input, 1 bit: operation enable; low = every register holds.
REQ-006 Port mode, input, 2 bits: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
REQ-007 Port data_in, input, WIDTH bits: parallel load data.
REQ-008 Port sin_r, input, 1 bit: serial input entering q[WIDTH-1] on shift right.
REQ-009 Port sin_l, input, 1 bit: serial input entering q[0] on shift left.
REQ-010 Port q, output, WIDTH bits: register contents; LSB is q[0].
REQ-011 Port sout, output, 1 bit: registered copy of the bit shifted out by the most recent shift.
REQ-012 Port cnt, output, $clog2(WIDTH+1) bits: number of shifts since the last load, saturating.
REQ-013 Port drained, output, 1 bit: high when cnt == WIDTH.

Function
REQ-014 The block SHALL update only on a rising clk edge with en=1 and rst high; with en=0, q, sout and cnt SHALL hold regardless of mode.
REQ-015 mode=00 SHALL hold q, sout and cnt.
REQ-016 mode=11 SHALL load q <= data_in and cnt <= 0 in one cycle, with sout unchanged; q SHALL show the new data the cycle after the edge.
REQ-017 mode=01 with ROTATE=0 SHALL set q <= {sin_r, q[WIDTH-1:1]} and sout <= old q[0].
REQ-018 mode=10 with ROTATE=0 SHALL set q <= {q[WIDTH-2:0], sin_l} and sout <= old q[WIDTH-1].
REQ-019 With ROTATE=1, shift right SHALL give q <= {q[0], q[WIDTH-1:1]} and shift left SHALL give q <= {q[WIDTH-2:0], q[WIDTH-1]}; sin_r and sin_l SHALL be ignored; sout SHALL follow the same rule as for ROTATE=0.
REQ-020 Each shift (01 or 10) SHALL increment cnt by 1 while cnt < WIDTH; at cnt == WIDTH, cnt SHALL saturate while shifting continues normally.
REQ-021 drained SHALL be combinational from cnt, with no extra latency.
REQ-022 A load on the same edge as a drained state SHALL clear cnt to 0 and drained to 0 on that edge.
REQ-023 Mixed-direction shifts SHALL each count as one shift; direction changes need no idle cycle.
REQ-024 Mode decode SHALL be full: no X propagation for any legal 2-bit mode value.

Reset
REQ-025 rst low SHALL immediately, without waiting for a clock, force q=0, sout=0 and cnt=0; drained SHALL then be 0.
REQ-026 Reset asserted mid-shift-sequence SHALL abort the sequence; the first operation after release SHALL be taken on the first rising clk edge with rst high.
REQ-027 Reset SHALL take priority over en and mode.

Verification
REQ-028 WIDTH=4, ROTATE=0: load 4'b1011, then 4x shift right with sin_r=0 -> q goes 0101, 0010, 0001, 0000; sout goes 1, 1, 0, 1; drained=1 after the 4th shift.
REQ-029 WIDTH=4, ROTATE=0: load 4'b0001, then 3x shift left with sin_l=1 -> q goes 0011, 0111, 1111; cnt=3; drained=0.
REQ-030 WIDTH=4, ROTATE=1: load 4'b1000, then 4x shift right with sin_r=1 -> q goes 0100, 0010, 0001, 1000; cnt=4.
REQ-031 en=0 with mode=11 and data_in=4'hF held for 3 cycles -> q, sout and cnt unchanged; then en=1 -> q=4'hF, cnt=0.
REQ-032 Drained at cnt=4, then 2 further shifts -> cnt stays 4; then a load -> cnt=0 and drained=0 on the next cycle.
REQ-033 Assert rst mid-cycle between clk edges after two shifts -> q, sout and cnt read 0 before the next edge; after release, load 4'hA -> q=4'hA.
